// File: rtl/bist_pattern_gen_if.sv
// Pattern handshake between the BIST generator and the circuit under test.
// The generator drives data/valid/last and the consumer returns ready.
interface bist_pattern_gen_if #(
  parameter int N = 4
);
  logic [N-1:0] pat_data;
  logic         pat_valid;
  logic         pat_last;
  logic         pat_ready;

  modport master (
    output pat_data,
    output pat_valid,
    output pat_last,
    input  pat_ready
  );

  modport slave (
    input  pat_data,
    input  pat_valid,
    input  pat_last,
    output pat_ready
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// LFSR test-pattern source and BIST run controller: emits PATTERN_COUNT
// patterns, drains the pipeline, then checks the MISR signature.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no run; waiting for start
// S_RUN   | presenting patterns; LFSR advances on each transfer
// S_DRAIN | letting the CUT/MISR pipeline settle for DRAIN_CYCLES
// S_CHECK | one cycle; sig_in compared against GOLDEN_SIG
// S_DONE  | result held; start launches a new run
module bist_pattern_gen #(
  parameter int                     LFSR_LENGTH    = 4,
  parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 4'b1101,
  parameter logic [LFSR_LENGTH-1:0] LFSR_SEED_VAL  = 4'b1011,
  parameter int                     PATTERN_COUNT  = 15,
  parameter int                     DRAIN_CYCLES   = 2,
  parameter logic [LFSR_LENGTH-1:0] GOLDEN_SIG     = 4'b0000,
  parameter int                     CNT_W          = 16
) (
  input  logic                   lfsr_clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LFSR_LENGTH-1:0] sig_in,
  bist_pattern_gen_if.master     pat,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       pat_cnt
);

  localparam int N = LFSR_LENGTH;

  // End bits of the polynomial never act as taps.
  localparam logic [N-1:0] END_BITS = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] TAP_MASK = LFSR_PRIM_POLY & ~END_BITS;

  localparam logic [CNT_W-1:0] LAST_IDX =
    (PATTERN_COUNT > 0) ? CNT_W'(PATTERN_COUNT - 1) : '0;

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD =
    (DRAIN_CYCLES > 0) ? DRN_W'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  localparam state_t AFTER_RUN   = (DRAIN_CYCLES > 0) ? S_DRAIN : S_CHECK;
  localparam state_t START_STATE = (PATTERN_COUNT > 0) ? S_RUN : AFTER_RUN;

  state_t           state;
  state_t           next_state;
  logic [N-1:0]     lfsr;
  logic [DRN_W-1:0] drn_cnt;
  logic             valid_q;
  logic             launch;
  logic             xfer;
  logic             last;
  logic             drn_tc;
  logic             fb;

  assign launch = start & ~abort & ((state == S_IDLE) | (state == S_DONE));
  assign xfer   = (state == S_RUN) & pat.pat_ready & ~abort;
  assign last   = (state == S_RUN) & (pat_cnt == LAST_IDX);
  assign drn_tc = (drn_cnt == '0);
  assign fb     = lfsr[N-1] ^ (^(lfsr & TAP_MASK));

  assign pat.pat_data  = lfsr;
  assign pat.pat_valid = valid_q;
  assign pat.pat_last  = last;

  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE,
      S_DONE:  if (launch) next_state = START_STATE;
      S_RUN:   if (xfer && last) next_state = AFTER_RUN;
      S_DRAIN: if (drn_tc) next_state = S_CHECK;
      S_CHECK: next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // A transfer in the same cycle as abort is dropped: xfer already masks it.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      lfsr    <= LFSR_SEED_VAL;
      pat_cnt <= '0;
    end else if (launch) begin
      lfsr    <= LFSR_SEED_VAL;
      pat_cnt <= '0;
    end else if (xfer) begin
      lfsr    <= {lfsr[N-2:0], fb};
      pat_cnt <= pat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      drn_cnt <= '0;
    end else if ((next_state == S_DRAIN) && (state != S_DRAIN)) begin
      drn_cnt <= DRN_LOAD;
    end else if ((state == S_DRAIN) && !drn_tc) begin
      drn_cnt <= drn_cnt - DRN_W'(1);
    end
  end

  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid_q <= (next_state == S_RUN);
      busy    <= (next_state == S_RUN) | (next_state == S_DRAIN) |
                 (next_state == S_CHECK);
      done    <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      pass <= 1'b0;
    end else if (abort || launch) begin
      pass <= 1'b0;
    end else if (state == S_CHECK) begin
      pass <= (sig_in == GOLDEN_SIG);
    end
  end

endmodule

// File: doc/bist_pattern_gen.md
# bist_pattern_gen

LFSR-based BIST test-pattern generator and run controller. It is the source end of the BIST datapath: it drives pseudo-random stimulus into the circuit under test, which feeds our MISR compactor. On a start pulse it emits a fixed number of patterns over a valid/ready handshake, waits for the pipeline to drain, then compares the MISR signature against a golden value and reports pass/fail.

## Interface
- LFSR_LENGTH, 4, pattern/LFSR width N (N >= 3)
- LFSR_PRIM_POLY, 4'b1101, tap mask; bits 1..N-2 select feedback taps; bits 0 and N-1 are ignored
- LFSR_SEED_VAL, 4'b1011, first pattern of every run; must be nonzero
- PATTERN_COUNT, 15, patterns per run (0 allowed)
- DRAIN_CYCLES, 2, wait cycles between last transfer and signature sample
- GOLDEN_SIG, 4'b0000, expected MISR signature
- CNT_W, 16, pattern counter width; PATTERN_COUNT < 2^CNT_W

Ports:
- lfsr_clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  single-cycle run request, honoured in IDLE or DONE only
- abort  in  1  terminates any run and returns to IDLE
- pat_ready  in  1  consumer accepts pat_data this cycle
- sig_in  in  N  MISR state (misr_state_out of the compactor)
- pat_data  out  N  current pattern (LFSR state)
- pat_valid  out  1  pat_data is valid
- pat_last  out  1  pat_data is the final pattern of the run
- busy  out  1  high in RUN, DRAIN and CHECK
- done  out  1  run complete; held until next start, abort or reset
- pass  out  1  signature matched; qualified by done
- pat_cnt  out  CNT_W  patterns transferred in the current run

## Operation
- LFSR: Fibonacci, shift-left. Feedback fb = lfsr[N-1] XOR (XOR of lfsr[i] for i in 1..N-2 where LFSR_PRIM_POLY[i] = 1). Next state = {lfsr[N-2:0], fb}.
- Default sequence (period 15): 1011, 0111, 1111, 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, then repeats from 1011.
- pat_data = lfsr continuously. The LFSR advances only on a transfer (pat_valid & pat_ready).
- FSM states:
  - IDLE: on start, load lfsr = seed and pat_cnt = 0, then go to RUN. If PATTERN_COUNT = 0, go to DRAIN instead (or CHECK if DRAIN_CYCLES = 0).
  - RUN: pat_valid = 1. Each transfer increments pat_cnt and advances the LFSR. pat_last = (pat_cnt == PATTERN_COUNT-1). A transfer with pat_last set goes to DRAIN, or to CHECK if DRAIN_CYCLES = 0.
  - DRAIN: count DRAIN_CYCLES cycles, then go to CHECK.
  - CHECK: one cycle. Register pass = (sig_in == GOLDEN_SIG), then go to DONE.
  - DONE: done = 1 and pass held. start behaves as in IDLE (reloads seed, clears done and pass, counter restarts).
- abort in any state goes to IDLE next cycle, clearing pat_valid, done and pass; pat_cnt holds its value. abort has priority over start and over a same-cycle transfer, and that transfer is not counted.
- start is ignored while busy.
- Runs with PATTERN_COUNT greater than the LFSR period wrap the sequence naturally.

## Timing
- Reset values: lfsr = LFSR_SEED_VAL, pat_valid = 0, pat_last = 0, busy = 0, done = 0, pass = 0, pat_cnt = 0, state IDLE. Reset mid-run returns to these values immediately.
- start sampled at edge k: pat_valid and busy are high from cycle k+1 with pat_data = seed.
- With pat_ready held high, one pattern transfers per cycle. The last transfer occurs at cycle k+PATTERN_COUNT.
- sig_in is sampled in the CHECK cycle, k+PATTERN_COUNT+DRAIN_CYCLES+1. done and pass become visible one cycle later.
- Backpressure (pat_ready low): pat_data, pat_last and pat_cnt hold stable; pat_valid never drops in RUN.
- All outputs are registered except pat_data (= lfsr register) and pat_last (decoded from registered state and pat_cnt).

## Test plan
- Defaults, pat_ready = 1, start at cycle 0: 15 patterns 1011…0101 on cycles 1..15, pat_last only with 0101, sig_in = 0000 → done and pass = 1 at cycle 19, pat_cnt = 15.
- Same run with sig_in = 0001 in CHECK → done = 1, pass = 0.
- pat_ready toggling 1,0,0,1…: no pattern is skipped or duplicated; data holds while ready is low; the received sequence equals the default sequence.
- PATTERN_COUNT = 20: pattern 16 = 1011, pattern 20 = 1100 with pat_last set.
- abort asserted with pat_cnt = 5 → IDLE next cycle, pat_valid = 0, done = 0. A following start restarts from 1011 with pat_cnt = 0.
- resetn pulsed low in DRAIN → all outputs at reset values asynchronously. start while busy is ignored; start in DONE clears done and begins a new run.
